// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: widths, flag bit positions,
// FSM state encoding and a flag-packing helper.
package alu_pkg;

    localparam int ALU_W = 4;
    localparam int FS_W  = 3;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } issue_state_e;

    function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                              input logic n, input logic z);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_settle_cnt.sv
// Loadable down-counter with zero flag; times how long the ALU inputs
// are held before the result is captured.
module alu_settle_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic [CW-1:0] o_cnt,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != {CW{1'b0}})) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == {CW{1'b0}});

endmodule

// File: rtl/alu_issue_unit.sv
// Sequential initiator for an external combinational ALU: command in,
// settle, capture, response out, with an accumulator for chaining.
// Optional sticky overflow flag enabled by defining ALU_ISSUE_STICKY_EN.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int W          = ALU_W,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic [FS_W-1:0]  cmd_fs,
    input  logic             cmd_use_acc,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [FS_W-1:0]  alu_fs,
    input  logic [W-1:0]     alu_y,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             alu_n,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_y,
    output logic [3:0]       rsp_flags,
`ifdef ALU_ISSUE_STICKY_EN
    input  logic             sticky_clr,
    output logic             sticky_v,
`endif
    output logic [W-1:0]     acc,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

    issue_state_e     r_state;
    issue_state_e     w_state_nxt;
    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic [W-1:0]     r_alu_a;
    logic [W-1:0]     r_alu_b;
    logic [FS_W-1:0]  r_alu_fs;
    logic [W-1:0]     r_rsp_y;
    logic [3:0]       r_rsp_flags;
    logic [W-1:0]     r_acc;
    logic [CNT_W-1:0] r_op_count;

    logic             w_accept;
    logic             w_capture;
    logic             w_retire;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic [3:0]       w_cnt;

    alu_settle_cnt #(.CW(4)) u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_load_val (SETTLE_LD),
        .i_dec      (w_cnt_dec),
        .o_cnt      (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    // Next-state decode and the three per-edge events: accept, capture, retire.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_retire    = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_DRIVE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_zero) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_retire    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, handshake flags and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_alu_a     <= {W{1'b0}};
            r_alu_b     <= {W{1'b0}};
            r_alu_fs    <= {FS_W{1'b0}};
            r_rsp_y     <= {W{1'b0}};
            r_rsp_flags <= 4'b0000;
            r_acc       <= {W{1'b0}};
            r_op_count  <= {CNT_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            if (w_accept) begin
                r_alu_a  <= cmd_use_acc ? r_acc : cmd_a;
                r_alu_b  <= cmd_b;
                r_alu_fs <= cmd_fs;
            end
            if (w_capture) begin
                r_rsp_y     <= alu_y;
                r_rsp_flags <= pack_flags(alu_c, alu_v, alu_n, alu_z);
            end
            // Accumulator updates as IDLE resumes, so a chained command sees it.
            if (w_retire) begin
                r_acc      <= r_rsp_y;
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

`ifdef ALU_ISSUE_STICKY_EN
    logic r_sticky_v;

    // Sticky overflow: a capture with V set wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_v <= 1'b0;
        end else if (w_capture && alu_v) begin
            r_sticky_v <= 1'b1;
        end else if (sticky_clr) begin
            r_sticky_v <= 1'b0;
        end
    end

    assign sticky_v = r_sticky_v;
`endif

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_fs    = r_alu_fs;
    assign rsp_y     = r_rsp_y;
    assign rsp_flags = r_rsp_flags;
    assign acc       = r_acc;
    assign op_count  = r_op_count;

endmodule
